// File: rtl/control_sequencer_pkg.sv
// rtl/control_sequencer_pkg.sv - shared types, opcodes and opcode classifier for the control sequencer
package cu_pkg;

  typedef struct packed {
    logic pc_out;
    logic mar_enable;
    logic pc_increment;
    logic z_enable;
    logic zlo_out;
    logic pc_enable;
    logic read;
    logic mdr_enable;
    logic mdr_out;
    logic ir_enable;
    logic gra;
    logic grb;
    logic grc;
    logic ba_out;
    logic y_enable;
    logic c_sign_extended_out;
    logic r_in;
    logic r_out;
    logic ram_write;
    logic inport_out;
    logic outport_enable;
    logic hi_out;
    logic lo_out;
  } cw_t;

  localparam int CW_W = $bits(cw_t);

  typedef enum logic [3:0] {
    S_IDLE, S_T0, S_T1, S_T2, S_DEC, S_T3, S_T4, S_T5, S_T6, S_T7, S_HALT
  } state_t;

  typedef enum logic [3:0] {
    ALU_R, ALU_I, LD, ST, IN, OUT, MFHI, MFLO, NOP, HALT, ILL
  } class_t;

  localparam logic [4:0] OP_LD    = 5'b00000;
  localparam logic [4:0] OP_LDI   = 5'b00001;
  localparam logic [4:0] OP_ST    = 5'b00010;
  localparam logic [4:0] OP_RLO   = 5'b00011;
  localparam logic [4:0] OP_RHI   = 5'b01011;
  localparam logic [4:0] OP_ADDI  = 5'b01100;
  localparam logic [4:0] OP_ANDI  = 5'b01101;
  localparam logic [4:0] OP_ORI   = 5'b01110;
  localparam logic [4:0] OP_IN    = 5'b10110;
  localparam logic [4:0] OP_OUT   = 5'b10111;
  localparam logic [4:0] OP_MFHI  = 5'b11000;
  localparam logic [4:0] OP_MFLO  = 5'b11001;
  localparam logic [4:0] OP_NOP   = 5'b11010;
  localparam logic [4:0] OP_HALT  = 5'b11011;

  function automatic class_t op_class(input logic [4:0] op);
    class_t c;
    c = ILL;
    if (op >= OP_RLO && op <= OP_RHI) c = ALU_R;
    else begin
      case (op)
        OP_LD:                             c = LD;
        OP_ST:                             c = ST;
        OP_LDI, OP_ADDI, OP_ANDI, OP_ORI:  c = ALU_I;
        OP_IN:                             c = IN;
        OP_OUT:                            c = OUT;
        OP_MFHI:                           c = MFHI;
        OP_MFLO:                           c = MFLO;
        OP_NOP:                            c = NOP;
        OP_HALT:                           c = HALT;
        default:                           c = ILL;
      endcase
    end
    return c;
  endfunction

endpackage

// File: rtl/control_sequencer_if.sv
// rtl/control_sequencer_if.sv - datapath-facing bundle: IR and memory handshake in, strobes and ALU op out
interface control_sequencer_if #(
  parameter int IRW = 32,
  parameter int OPW = 5
) ();
  import cu_pkg::*;

  logic [IRW-1:0] ir;
  logic           mem_ready;
  cw_t            ctrl;
  logic [OPW-1:0] alu_op;

  modport master (input ir, mem_ready, output ctrl, alu_op);
  modport slave  (output ir, mem_ready, input ctrl, alu_op);
endinterface

// File: rtl/control_sequencer_decode.sv
// rtl/control_sequencer_decode.sv - combinational map from (T-state, instruction class) to control word
module cu_decode
  import cu_pkg::*;
(
  input  state_t state,
  input  class_t cls,
  output cw_t    ctrl
);

  always_comb begin
    ctrl = '0;
    case (state)
      S_T0: begin
        ctrl.pc_out = 1'b1; ctrl.mar_enable = 1'b1;
        ctrl.pc_increment = 1'b1; ctrl.z_enable = 1'b1;
      end
      S_T1: begin
        ctrl.zlo_out = 1'b1; ctrl.pc_enable = 1'b1;
        ctrl.read = 1'b1; ctrl.mdr_enable = 1'b1;
      end
      S_T2: begin
        ctrl.mdr_out = 1'b1; ctrl.ir_enable = 1'b1;
      end
      S_T3: begin
        case (cls)
          ALU_I, LD, ST: begin ctrl.grb = 1'b1; ctrl.ba_out = 1'b1; ctrl.y_enable = 1'b1; end
          ALU_R:         begin ctrl.grb = 1'b1; ctrl.r_out = 1'b1; ctrl.y_enable = 1'b1; end
          IN:            begin ctrl.inport_out = 1'b1; ctrl.gra = 1'b1; ctrl.r_in = 1'b1; end
          OUT:           begin ctrl.gra = 1'b1; ctrl.r_out = 1'b1; ctrl.outport_enable = 1'b1; end
          MFHI:          begin ctrl.hi_out = 1'b1; ctrl.gra = 1'b1; ctrl.r_in = 1'b1; end
          MFLO:          begin ctrl.lo_out = 1'b1; ctrl.gra = 1'b1; ctrl.r_in = 1'b1; end
          default:       ;
        endcase
      end
      S_T4: begin
        case (cls)
          ALU_I, LD, ST: begin ctrl.c_sign_extended_out = 1'b1; ctrl.z_enable = 1'b1; end
          ALU_R:         begin ctrl.grc = 1'b1; ctrl.r_out = 1'b1; ctrl.z_enable = 1'b1; end
          default:       ;
        endcase
      end
      S_T5: begin
        case (cls)
          ALU_I, ALU_R:  begin ctrl.zlo_out = 1'b1; ctrl.gra = 1'b1; ctrl.r_in = 1'b1; end
          LD, ST:        begin ctrl.zlo_out = 1'b1; ctrl.mar_enable = 1'b1; end
          default:       ;
        endcase
      end
      S_T6: begin
        case (cls)
          LD:      begin ctrl.read = 1'b1; ctrl.mdr_enable = 1'b1; end
          ST:      begin ctrl.gra = 1'b1; ctrl.r_out = 1'b1; ctrl.mdr_enable = 1'b1; end
          default: ;
        endcase
      end
      S_T7: begin
        case (cls)
          LD:      begin ctrl.mdr_out = 1'b1; ctrl.gra = 1'b1; ctrl.r_in = 1'b1; end
          ST:      ctrl.ram_write = 1'b1;
          default: ;
        endcase
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/control_sequencer.sv
// rtl/control_sequencer.sv - hardwired T-state sequencer with run/step, memory stalls, halt and retire counter
module control_sequencer
  import cu_pkg::*;
#(
  parameter int IRW         = 32,
  parameter int OPW         = 5,
  parameter int STEP_CYCLES = 1,
  parameter int CNT_W       = 16
) (
  input  logic                  clk,
  input  logic                  clr,
  input  logic                  run,
  input  logic                  step,
  control_sequencer_if.master   dp,
  output logic                  busy,
  output logic                  halted,
  output logic                  illegal,
  output logic [CNT_W-1:0]      instr_count
);

  localparam logic [1:0] HOLD_MAX = 2'(STEP_CYCLES - 1);

  state_t         state, state_nx;
  logic [1:0]     hold_cnt, hold_nx;
  logic [OPW-1:0] opcode_q;
  class_t         cls_q, cls_ir;
  logic           mem_state, advance, last_t, retire;
  cw_t            cw;

  // cls_ir is only meaningful in DEC, once the IR has been loaded in T2
  assign cls_q  = op_class(5'(opcode_q));
  assign cls_ir = op_class(5'(dp.ir[IRW-1 -: OPW]));

  always_comb begin
    mem_state = (state == S_T1) || (state == S_T6 && cls_q == LD) ||
                (state == S_T7 && cls_q == ST);
    advance   = (hold_cnt == HOLD_MAX) && (!mem_state || dp.mem_ready);
    case (state)
      S_DEC:   last_t = (cls_ir == NOP) || (cls_ir == ILL);
      S_T3:    last_t = (cls_q == IN) || (cls_q == OUT) || (cls_q == MFHI) || (cls_q == MFLO);
      S_T5:    last_t = (cls_q == ALU_R) || (cls_q == ALU_I);
      S_T7:    last_t = 1'b1;
      default: last_t = 1'b0;
    endcase
  end

  always_comb begin
    state_nx = state;
    retire   = 1'b0;
    hold_nx  = hold_cnt;
    case (state)
      S_IDLE: if (run || step) state_nx = S_T0;
      S_HALT: state_nx = S_HALT;
      default: begin
        if (advance) begin
          if (state == S_DEC && cls_ir == HALT) begin
            state_nx = S_HALT;
            retire   = 1'b1;
          end else if (last_t) begin
            state_nx = run ? S_T0 : S_IDLE;
            retire   = 1'b1;
          end else begin
            state_nx = state_t'(state + 4'd1);
          end
        end
      end
    endcase
    // a stalled memory T-state freezes the hold counter along with the state
    if (state == S_IDLE || state == S_HALT) hold_nx = '0;
    else if (mem_state && !dp.mem_ready)    hold_nx = hold_cnt;
    else if (hold_cnt == HOLD_MAX)          hold_nx = '0;
    else                                    hold_nx = hold_cnt + 2'd1;
  end

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      state       <= S_IDLE;
      hold_cnt    <= '0;
      opcode_q    <= '0;
      instr_count <= '0;
    end else begin
      state    <= state_nx;
      hold_cnt <= hold_nx;
      if (state == S_DEC) opcode_q <= dp.ir[IRW-1 -: OPW];
      if (retire) instr_count <= instr_count + 1'b1;
    end
  end

  cu_decode u_decode (
    .state (state),
    .cls   (cls_q),
    .ctrl  (cw)
  );

  assign dp.ctrl   = cw;
  assign dp.alu_op = opcode_q;
  assign busy      = (state != S_IDLE) && (state != S_HALT);
  assign halted    = (state == S_HALT);
  assign illegal   = (state == S_DEC) && (hold_cnt == 2'd0) && (cls_ir == ILL);

endmodule

// File: tb/tb_control_sequencer.sv
// tb/tb_control_sequencer.sv - directed self-checking bench for control_sequencer
module tb_control_sequencer;
  import cu_pkg::*;

  logic clk = 1'b0;
  logic clr = 1'b0;
  logic run1 = 1'b0, step1 = 1'b0, run2 = 1'b0, step2 = 1'b0;
  logic busy1, halted1, illegal1, busy2, halted2, illegal2;
  logic [15:0] count1;
  logic [1:0]  count2;
  int n_checks = 0;
  int n_fail = 0;

  cw_t w_t0, w_t1, w_t2, w_i_t3, w_r_t3, w_r_t4, w_i_t5, w_ld_t6, w_ld_t7, w_st_t6, w_st_t7;

  always #5 clk = ~clk;

  control_sequencer_if #(.IRW(32), .OPW(5)) dp1 ();
  control_sequencer_if #(.IRW(32), .OPW(5)) dp2 ();

  control_sequencer #(.IRW(32), .OPW(5), .STEP_CYCLES(1), .CNT_W(16)) dut1 (
    .clk(clk), .clr(clr), .run(run1), .step(step1), .dp(dp1.master),
    .busy(busy1), .halted(halted1), .illegal(illegal1), .instr_count(count1));

  control_sequencer #(.IRW(32), .OPW(5), .STEP_CYCLES(2), .CNT_W(2)) dut2 (
    .clk(clk), .clr(clr), .run(run2), .step(step2), .dp(dp2.master),
    .busy(busy2), .halted(halted2), .illegal(illegal2), .instr_count(count2));

  task init_words;
    w_t0 = '0; w_t0.pc_out = 1; w_t0.mar_enable = 1; w_t0.pc_increment = 1; w_t0.z_enable = 1;
    w_t1 = '0; w_t1.zlo_out = 1; w_t1.pc_enable = 1; w_t1.read = 1; w_t1.mdr_enable = 1;
    w_t2 = '0; w_t2.mdr_out = 1; w_t2.ir_enable = 1;
    w_i_t3 = '0; w_i_t3.grb = 1; w_i_t3.ba_out = 1; w_i_t3.y_enable = 1;
    w_r_t3 = '0; w_r_t3.grb = 1; w_r_t3.r_out = 1; w_r_t3.y_enable = 1;
    w_r_t4 = '0; w_r_t4.grc = 1; w_r_t4.r_out = 1; w_r_t4.z_enable = 1;
    w_i_t5 = '0; w_i_t5.zlo_out = 1; w_i_t5.gra = 1; w_i_t5.r_in = 1;
    w_ld_t6 = '0; w_ld_t6.read = 1; w_ld_t6.mdr_enable = 1;
    w_ld_t7 = '0; w_ld_t7.mdr_out = 1; w_ld_t7.gra = 1; w_ld_t7.r_in = 1;
    w_st_t6 = '0; w_st_t6.gra = 1; w_st_t6.r_out = 1; w_st_t6.mdr_enable = 1;
    w_st_t7 = '0; w_st_t7.ram_write = 1;
  endtask

  task test_reset;
    clr = 1'b0;
    dp1.mem_ready = 1'b1; dp2.mem_ready = 1'b1; dp1.ir = '0; dp2.ir = '0;
    repeat (2) @(negedge clk);
    n_checks++; if (dp1.ctrl !== cw_t'('0)) begin n_fail++; $display("FAIL reset_ctrl: got %0h expected 0", dp1.ctrl); end
    n_checks++; if (dp1.alu_op !== 5'd0) begin n_fail++; $display("FAIL reset_alu_op: got %0h expected 0", dp1.alu_op); end
    n_checks++; if ({busy1, halted1, illegal1} !== 3'b000) begin n_fail++; $display("FAIL reset_flags: got %b expected 000", {busy1, halted1, illegal1}); end
    n_checks++; if (count1 !== 16'd0) begin n_fail++; $display("FAIL reset_count: got %0d expected 0", count1); end
    clr = 1'b1;
    @(negedge clk);
  endtask

  task test_ldi;
    dp1.ir = {5'b00001, 27'd0};
    run1 = 1'b1;
    for (int c = 1; c <= 8; c++) begin
      @(negedge clk);
      if (c == 1) begin
        n_checks++; if (dp1.ctrl !== w_t0) begin n_fail++; $display("FAIL ldi_t0: got %0h expected %0h", dp1.ctrl, w_t0); end
        run1 = 1'b0;
      end
      if (c == 2) begin n_checks++; if (dp1.ctrl !== w_t1) begin n_fail++; $display("FAIL ldi_t1: got %0h expected %0h", dp1.ctrl, w_t1); end end
      if (c == 3) begin n_checks++; if (dp1.ctrl !== w_t2) begin n_fail++; $display("FAIL ldi_t2: got %0h expected %0h", dp1.ctrl, w_t2); end end
      if (c == 4) begin n_checks++; if (dp1.ctrl !== cw_t'('0)) begin n_fail++; $display("FAIL ldi_dec: got %0h expected 0", dp1.ctrl); end end
      if (c == 5) begin
        n_checks++; if (dp1.ctrl !== w_i_t3) begin n_fail++; $display("FAIL ldi_t3: got %0h expected %0h", dp1.ctrl, w_i_t3); end
        n_checks++; if (dp1.alu_op !== 5'b00001) begin n_fail++; $display("FAIL ldi_alu_op: got %0h expected 1", dp1.alu_op); end
      end
      if (c == 7) begin n_checks++; if (dp1.ctrl !== w_i_t5) begin n_fail++; $display("FAIL ldi_t5: got %0h expected %0h", dp1.ctrl, w_i_t5); end end
      if (c == 8) begin
        n_checks++; if (busy1 !== 1'b0) begin n_fail++; $display("FAIL ldi_idle: got busy %b expected 0", busy1); end
        n_checks++; if (count1 !== 16'd1) begin n_fail++; $display("FAIL ldi_count: got %0d expected 1", count1); end
      end
    end
  endtask

  task test_ld_mem_wait;
    int nbusy;
    nbusy = 0;
    dp1.ir = {5'b00000, 27'd0};
    run1 = 1'b1;
    for (int c = 1; c <= 13; c++) begin
      @(negedge clk);
      if (busy1) nbusy++;
      if (c == 1) begin run1 = 1'b0; dp1.mem_ready = 1'b0; end
      if (c >= 2 && c <= 5) begin
        n_checks++; if (dp1.ctrl !== w_t1) begin n_fail++; $display("FAIL ld_t1_hold c%0d: got %0h expected %0h", c, dp1.ctrl, w_t1); end
      end
      if (c == 5) dp1.mem_ready = 1'b1;
      if (c == 11) begin n_checks++; if (dp1.ctrl !== w_ld_t6) begin n_fail++; $display("FAIL ld_t6: got %0h expected %0h", dp1.ctrl, w_ld_t6); end end
      if (c == 12) begin n_checks++; if (dp1.ctrl !== w_ld_t7) begin n_fail++; $display("FAIL ld_t7: got %0h expected %0h", dp1.ctrl, w_ld_t7); end end
      if (c == 13) begin n_checks++; if (count1 !== 16'd2) begin n_fail++; $display("FAIL ld_count: got %0d expected 2", count1); end end
    end
    n_checks++; if (nbusy != 12) begin n_fail++; $display("FAIL ld_latency: got %0d expected 12", nbusy); end
  endtask

  task test_step2_out;
    int nbusy, noe;
    nbusy = 0; noe = 0;
    dp2.ir = {5'b10111, 27'd0};
    run2 = 1'b1;
    for (int c = 1; c <= 12; c++) begin
      @(negedge clk);
      if (busy2) nbusy++;
      if (dp2.ctrl.outport_enable) noe++;
      if (c == 1) run2 = 1'b0;
      if (c == 2) begin n_checks++; if (dp2.ctrl !== w_t0) begin n_fail++; $display("FAIL out2_t0_hold: got %0h expected %0h", dp2.ctrl, w_t0); end end
      if (c == 3) begin n_checks++; if (dp2.ctrl !== w_t1) begin n_fail++; $display("FAIL out2_t1: got %0h expected %0h", dp2.ctrl, w_t1); end end
    end
    n_checks++; if (nbusy != 10) begin n_fail++; $display("FAIL out2_latency: got %0d expected 10", nbusy); end
    n_checks++; if (noe != 2) begin n_fail++; $display("FAIL out2_oe_cycles: got %0d expected 2", noe); end
    n_checks++; if (count2 !== 2'd1) begin n_fail++; $display("FAIL out2_count: got %0d expected 1", count2); end
  endtask

  task test_back_to_back;
    int nbusy;
    nbusy = 0;
    run2 = 1'b1;
    for (int c = 1; c <= 41; c++) begin
      @(negedge clk);
      if (c <= 40 && busy2) nbusy++;
      if (c == 11) begin n_checks++; if (count2 !== 2'd2) begin n_fail++; $display("FAIL b2b_count11: got %0d expected 2", count2); end end
      if (c == 31) begin
        n_checks++; if (count2 !== 2'd0) begin n_fail++; $display("FAIL b2b_wrap: got %0d expected 0", count2); end
        run2 = 1'b0;
      end
      if (c == 41) begin
        n_checks++; if (count2 !== 2'd1) begin n_fail++; $display("FAIL b2b_count41: got %0d expected 1", count2); end
        n_checks++; if (busy2 !== 1'b0) begin n_fail++; $display("FAIL b2b_idle: got busy %b expected 0", busy2); end
      end
    end
    n_checks++; if (nbusy != 40) begin n_fail++; $display("FAIL b2b_busy: got %0d expected 40", nbusy); end
  endtask

  task test_step_add;
    int nbusy;
    nbusy = 0;
    dp1.ir = {5'b00011, 27'd0};
    step1 = 1'b1;
    for (int c = 1; c <= 12; c++) begin
      @(negedge clk);
      if (busy1) nbusy++;
      if (c == 1) step1 = 1'b0;
      if (c == 3) step1 = 1'b1;
      if (c == 4) step1 = 1'b0;
      if (c == 5) begin n_checks++; if (dp1.ctrl !== w_r_t3) begin n_fail++; $display("FAIL add_t3: got %0h expected %0h", dp1.ctrl, w_r_t3); end end
      if (c == 6) begin n_checks++; if (dp1.ctrl !== w_r_t4) begin n_fail++; $display("FAIL add_t4: got %0h expected %0h", dp1.ctrl, w_r_t4); end end
    end
    n_checks++; if (nbusy != 7) begin n_fail++; $display("FAIL add_busy: got %0d expected 7", nbusy); end
    n_checks++; if (count1 !== 16'd3) begin n_fail++; $display("FAIL add_count: got %0d expected 3", count1); end
  endtask

  task test_clr_mid_st;
    dp1.ir = {5'b00010, 27'd0};
    step1 = 1'b1;
    for (int c = 1; c <= 9; c++) begin
      @(negedge clk);
      if (c == 1) step1 = 1'b0;
      if (c == 8) begin n_checks++; if (dp1.ctrl !== w_st_t6) begin n_fail++; $display("FAIL st_t6: got %0h expected %0h", dp1.ctrl, w_st_t6); end end
      if (c == 9) begin
        n_checks++; if (dp1.ctrl !== w_st_t7) begin n_fail++; $display("FAIL st_t7: got %0h expected %0h", dp1.ctrl, w_st_t7); end
        n_checks++; if (count1 !== 16'd3) begin n_fail++; $display("FAIL st_count_pre: got %0d expected 3", count1); end
      end
    end
    #2 clr = 1'b0;
    #1;
    n_checks++; if (dp1.ctrl !== cw_t'('0)) begin n_fail++; $display("FAIL clr_ctrl: got %0h expected 0", dp1.ctrl); end
    n_checks++; if (count1 !== 16'd0) begin n_fail++; $display("FAIL clr_count: got %0d expected 0", count1); end
    n_checks++; if (busy1 !== 1'b0) begin n_fail++; $display("FAIL clr_busy: got %b expected 0", busy1); end
    @(negedge clk);
    clr = 1'b1;
    @(negedge clk);
    n_checks++; if (busy1 !== 1'b0) begin n_fail++; $display("FAIL clr_stays_idle: got %b expected 0", busy1); end
  endtask

  task test_illegal;
    int nill, nrin, nbusy;
    nill = 0; nrin = 0; nbusy = 0;
    dp1.ir = {5'b11111, 27'd0};
    step1 = 1'b1;
    for (int c = 1; c <= 6; c++) begin
      @(negedge clk);
      if (illegal1) nill++;
      if (dp1.ctrl.r_in) nrin++;
      if (busy1) nbusy++;
      if (c == 1) step1 = 1'b0;
      if (c == 4) begin n_checks++; if (illegal1 !== 1'b1) begin n_fail++; $display("FAIL ill_dec: got %b expected 1", illegal1); end end
    end
    n_checks++; if (nill != 1) begin n_fail++; $display("FAIL ill_pulses: got %0d expected 1", nill); end
    n_checks++; if (nrin != 0) begin n_fail++; $display("FAIL ill_r_in: got %0d expected 0", nrin); end
    n_checks++; if (nbusy != 4) begin n_fail++; $display("FAIL ill_busy: got %0d expected 4", nbusy); end
    n_checks++; if (count1 !== 16'd1) begin n_fail++; $display("FAIL ill_count: got %0d expected 1", count1); end
  endtask

  task test_halt;
    dp1.ir = {5'b11011, 27'd0};
    step1 = 1'b1;
    for (int c = 1; c <= 5; c++) begin
      @(negedge clk);
      if (c == 1) step1 = 1'b0;
    end
    n_checks++; if (halted1 !== 1'b1) begin n_fail++; $display("FAIL halt_flag: got %b expected 1", halted1); end
    n_checks++; if (busy1 !== 1'b0) begin n_fail++; $display("FAIL halt_busy: got %b expected 0", busy1); end
    run1 = 1'b1;
    for (int c = 1; c <= 6; c++) begin
      @(negedge clk);
      n_checks++; if ({halted1, dp1.ctrl} !== {1'b1, cw_t'('0)}) begin n_fail++; $display("FAIL halt_sticky c%0d: got halted %b ctrl %0h expected 1 0", c, halted1, dp1.ctrl); end
    end
    run1 = 1'b0;
    clr = 1'b0;
    @(negedge clk);
    n_checks++; if (halted1 !== 1'b0) begin n_fail++; $display("FAIL halt_clr: got %b expected 0", halted1); end
    clr = 1'b1;
    @(negedge clk);
  endtask

  initial begin
    init_words();
    test_reset();
    test_ldi();
    test_ld_mem_wait();
    test_step2_out();
    test_back_to_back();
    test_step_add();
    test_clr_mid_st();
    test_illegal();
    test_halt();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/control_sequencer.md
# control_sequencer

Parametrised hardwired control unit for the Phase-3 RISC datapath. It generates the per-T-state control strobes for the datapath instead of a hand-written bench FSM. It fetches, decodes the opcode field of the IR and sequences the T-states for the supported instruction classes. It adds run/single-step control, memory-wait stalls, halt, illegal-opcode flagging and a retired-instruction counter.

## Interface
Parameters:
- `IRW`, 32: IR width; opcode is `ir[IRW-1 -: OPW]`.
- `OPW`, 5: opcode width.
- `STEP_CYCLES`, 1: clocks each T-state is held (1..4).
- `CNT_W`, 16: retired-instruction counter width.

Ports:
- `clk`  in  1  clock; all state changes on rising edge.
- `clr`  in  1  asynchronous, active-low reset.
- `run`  in  1  level; free-running execution while high.
- `step`  in  1  single-cycle pulse; executes exactly one instruction when `run`=0.
- `mem_ready`  in  1  memory handshake; low stalls memory T-states.
- `ir`  in  IRW  current IR contents from the datapath.
- `ctrl`  out  CW_W  packed control word (`cw_t`), one bit per datapath strobe.
- `alu_op`  out  OPW  ALU operation (latched opcode).
- `busy`  out  1  high from T0 to end of last T-state.
- `halted`  out  1  sticky after `halt` retires.
- `illegal`  out  1  one-cycle pulse in DEC on an unsupported opcode.
- `instr_count`  out  CNT_W  retired instructions, wraps modulo 2^CNT_W.

## Operation
- States: IDLE, T0, T1, T2, DEC, T3..T7, HALT.
- IDLE -> T0 when `run`=1, or when `step`=1 with `run`=0. `step` is ignored while `busy` or `run`=1.
- Fetch, common to all instructions:
  - T0: pc_out, mar_enable, pc_increment, z_enable.
  - T1: zlo_out, pc_enable, read, mdr_enable.
  - T2: mdr_out, ir_enable.
  - DEC: no strobes; `opcode_q <= ir[IRW-1 -: OPW]`.
- ldi/addi/andi/ori (00001, 01100, 01101, 01110):
  - T3: grb, ba_out, y_enable.
  - T4: c_sign_extended_out, z_enable.
  - T5: zlo_out, gra, r_in.
- R-type (00011–01011):
  - T3: grb, r_out, y_enable.
  - T4: grc, r_out, z_enable.
  - T5: zlo_out, gra, r_in.
- ld (00000):
  - T3–T4 as ldi.
  - T5: zlo_out, mar_enable.
  - T6: read, mdr_enable.
  - T7: mdr_out, gra, r_in.
- st (00010):
  - T3–T5 as ld.
  - T6: gra, r_out, mdr_enable.
  - T7: ram_write.
- in (10110): T3 inport_out, gra, r_in.
- out (10111): T3 gra, r_out, outport_enable.
- mfhi/mflo (11000/11001): T3 hi_out/lo_out, gra, r_in.
- nop (11010): retires after DEC.
- halt (11011): DEC -> HALT; `halted`=1; only `clr` exits.
- Any other opcode: `illegal` pulses in DEC; treated as nop.
- After the last T-state: `instr_count`+1; go to T0 if `run`=1, else IDLE.

## Timing
- Reset (async, `clr`=0): state IDLE, `ctrl`=0, `alu_op`=0, `busy`=0, `halted`=0, `illegal`=0, `instr_count`=0. Strobes drop immediately, including mid-instruction.
- `ctrl` and `alu_op` are decoded only from registered state/`opcode_q`; no input-to-output combinational path.
- Each T-state lasts `STEP_CYCLES` clocks; its strobes are held for the whole period.
- Instruction latency at `STEP_CYCLES`=1, `mem_ready`=1:
  - nop: 4 clocks.
  - in/out/mf*: 5 clocks.
  - ldi/ALU: 7 clocks.
  - ld/st: 9 clocks.
- Memory T-states are T1, ld T6 and st T7. While `mem_ready`=0 in one of them, the state and strobes are held and the hold counter is frozen. The state advances only after `STEP_CYCLES` clocks with `mem_ready`=1 on the last.
- `run` falling mid-instruction: the instruction completes, then the block goes to IDLE.
- `instr_count` increments on the clock leaving the last T-state; it wraps to 0.

## Structure
- Package `cu_pkg` holds:
  - `cw_t`, a packed struct of all strobes, with `CW_W`.
  - `state_t` enum.
  - opcode localparams.
  - `class_t` enum (ALU_R, ALU_I, LD, ST, IN, OUT, MFHI, MFLO, NOP, HALT, ILL).
- One sub-module, `cu_decode`: combinational, maps (`state_t`, `class_t`) to `cw_t`. The sequencer holds the FSM, hold counter and counters.

## Test plan
- Reset then `run`=1, IR=ldi opcode 00001 → T0..T5 order; r_in with gra in cycle 7; `instr_count`=1.
- `mem_ready`=0 for 3 clocks in T1 of an ld → T1 strobes held 4 clocks; ld completes in 12 clocks.
- `STEP_CYCLES`=2, out 10111 → every T-state held 2 clocks; outport_enable asserted 2 clocks; 10 clocks total.
- `run`=0, one `step` pulse with add 00011 → exactly 7 busy clocks, then IDLE; a second `step` during busy is ignored.
- IR=11111 → `illegal` one pulse in DEC, no register strobes, count+1. Then halt 11011 → `halted`=1, `ctrl`=0 forever until `clr`.
- `clr` low during st T7 → `ctrl`=0 asynchronously, `instr_count`=0, state IDLE.
